// File: rtl/spi_target.sv
// spi_target: SPI target (slave) PHY.
// Synchronizes the asynchronous sck/mosi/cs_n pins onto clk100mhz, shifts in
// 1..32-bit words and shifts out words preloaded through a single-entry TX
// holding register. All four CPOL/CPHA modes, multiple words per CS_n frame.
//
// Ports
//   clk100mhz, rst      system clock, synchronous active-high reset
//   cpol, cpha          SPI mode, latched at frame start
//   len[4:0]            word length minus 1, latched at each word start
//   tx_data/valid/ready response word handshake (bit [len] sent first)
//   rx_data, rx_valid   received word (right-aligned) and its one-cycle strobe
//   tx_underrun         word started with an empty holding register
//   abort               CS_n deasserted mid-word
//   busy                frame active
//   sck, mosi, cs_n     asynchronous pins
//   miso, miso_oe       serial data out and its tri-state enable
//
// state  | meaning
// IDLE   | waiting for a cs_n falling edge; pin activity ignored
// ACTIVE | frame in progress; shifting words until cs_n rises
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk100mhz,
  input  logic        rst,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [4:0]  len,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        tx_underrun,
  output logic        abort,
  output logic        busy,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_ff, mosi_ff, cs_ff;
  logic sck_d, cs_d, mosi_q;
  logic ev_sck_rise, ev_sck_fall, ev_cs_rise, ev_cs_fall;

  // The cs_n chain and its edge register reset to "low" so a falling edge
  // can only be seen after cs_n has been observed high. A reset taken
  // mid-frame therefore ignores the remainder of that frame.
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      sck_ff      <= '0;
      mosi_ff     <= '0;
      cs_ff       <= '0;
      sck_d       <= 1'b0;
      cs_d        <= 1'b0;
      mosi_q      <= 1'b0;
      ev_sck_rise <= 1'b0;
      ev_sck_fall <= 1'b0;
      ev_cs_rise  <= 1'b0;
      ev_cs_fall  <= 1'b0;
    end else begin
      sck_ff      <= {sck_ff[SYNC_STAGES-2:0], sck};
      mosi_ff     <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      cs_ff       <= {cs_ff[SYNC_STAGES-2:0], cs_n};
      sck_d       <= sck_ff[SYNC_STAGES-1];
      cs_d        <= cs_ff[SYNC_STAGES-1];
      // Events are registered together with mosi so the sampled bit lines
      // up with the sck edge that selected it.
      mosi_q      <= mosi_ff[SYNC_STAGES-1];
      ev_sck_rise <= sck_ff[SYNC_STAGES-1] & ~sck_d;
      ev_sck_fall <= ~sck_ff[SYNC_STAGES-1] & sck_d;
      ev_cs_rise  <= cs_ff[SYNC_STAGES-1] & ~cs_d;
      ev_cs_fall  <= ~cs_ff[SYNC_STAGES-1] & cs_d;
    end
  end

  logic        cpol_q, cpha_q;
  logic [4:0]  len_q;
  logic [5:0]  cnt;
  logic        word_pending;
  logic [31:0] tx_sr;
  logic [30:0] rx_sr;
  logic [31:0] hold;
  logic        hold_full;

  logic sck_lead, sck_trail, shift_edge, sample_edge;
  logic frame_start, frame_end, word_start, shift_bit, sample_bit;

  assign sck_lead    = cpol_q ? ev_sck_fall : ev_sck_rise;
  assign sck_trail   = cpol_q ? ev_sck_rise : ev_sck_fall;
  assign shift_edge  = cpha_q ? sck_lead : sck_trail;
  assign sample_edge = cpha_q ? sck_trail : sck_lead;

  always_ff @(posedge clk100mhz) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    word_start  = 1'b0;
    shift_bit   = 1'b0;
    sample_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (ev_cs_fall) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
          // cpha=0 drives the first MSB right away; cpha=1 waits for the
          // first leading edge.
          word_start  = ~cpha;
        end
      end
      ACTIVE: begin
        if (ev_cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          if (shift_edge) begin
            if (word_pending)  word_start = 1'b1;
            else if (cnt != 0) shift_bit  = 1'b1;
          end
          sample_bit = sample_edge & ~word_pending;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [31:0] load_word, rx_next, rx_mask;
  logic [4:0]  shift_idx;

  assign load_word = hold_full ? hold : 32'd0;
  assign shift_idx = len_q - cnt[4:0];
  assign rx_next   = {rx_sr, mosi_q};
  assign rx_mask   = ~(32'hFFFF_FFFE << len_q);

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      len_q        <= '0;
      cnt          <= '0;
      word_pending <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_underrun  <= 1'b0;
      abort        <= 1'b0;
      hold         <= '0;
      hold_full    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      abort       <= 1'b0;

      if (frame_start) begin
        cpol_q       <= cpol;
        cpha_q       <= cpha;
        cnt          <= '0;
        word_pending <= cpha;
      end

      if (frame_end) begin
        word_pending <= 1'b0;
        cnt          <= '0;
        if (cnt != 0) abort <= 1'b1;
      end

      if (word_start) begin
        len_q        <= len;
        tx_sr        <= load_word;
        miso         <= load_word[len];
        tx_underrun  <= ~hold_full;
        cnt          <= '0;
        word_pending <= 1'b0;
      end

      if (shift_bit) miso <= tx_sr[shift_idx];

      if (sample_bit) begin
        rx_sr <= rx_next[30:0];
        if (cnt == {1'b0, len_q}) begin
          rx_data      <= rx_next & rx_mask;
          rx_valid     <= 1'b1;
          cnt          <= '0;
          word_pending <= 1'b1;
        end else begin
          cnt <= cnt + 6'd1;
        end
      end

      // Consumption sees the old contents; a write lands only if the
      // register was already empty going into this cycle.
      if (word_start) hold_full <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state == ACTIVE);
  assign miso_oe  = busy;

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  logic        clk100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [4:0]  len = 5'd7;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        tx_underrun;
  logic        abort;
  logic        busy;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic        miso_oe;

  localparam int HALF = 5;

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk100mhz  (clk100mhz),
    .rst        (rst),
    .cpol       (cpol),
    .cpha       (cpha),
    .len        (len),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .abort      (abort),
    .busy       (busy),
    .sck        (sck),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .miso_oe    (miso_oe)
  );

  always #5 clk100mhz = ~clk100mhz;

  int checks = 0;
  int passed = 0;
  int rx_cnt = 0;
  int und_cnt = 0;
  int ab_cnt = 0;
  int rd_idx = 0;
  logic [31:0] exp_rx[$];
  logic [31:0] obs_rx[$];

  // Monitor: records every received word and counts pulses.
  always @(negedge clk100mhz) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_cnt++;
        obs_rx.push_back(rx_data);
      end
      if (tx_underrun) und_cnt++;
      if (abort) ab_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100mhz);
  endtask

  function automatic logic [31:0] len_mask(input logic [4:0] l);
    logic [63:0] m;
    m = (64'd1 << (int'(l) + 1)) - 64'd1;
    return m[31:0];
  endfunction

  task automatic load_tx(input logic [31:0] d);
    int k = 0;
    while (tx_ready !== 1'b1 && k < 1000) begin
      tick(1);
      k++;
    end
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL load_tx_timeout: tx_ready=%b required 1", tx_ready);
    else passed++;
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic frame_begin(input logic cp, input logic ch);
    cpol = cp;
    cpha = ch;
    sck  = cp;
    tick(8);
    cs_n = 1'b0;
    tick(10);
  endtask

  task automatic frame_end();
    tick(5);
    cs_n = 1'b1;
    tick(10);
  endtask

  // Controller model: sends nbits of w MSB (bit len) first, captures miso
  // at each sample edge. A full word is pushed to the scoreboard.
  task automatic spi_bits(input logic [31:0] w, input int nbits, output logic [31:0] cap);
    cap = '0;
    for (int b = 0; b < nbits; b++) begin
      int i;
      i = int'(len) - b;
      if (!cpha) begin
        mosi = w[i];
        tick(HALF);
        sck = ~cpol;
        cap[i] = miso;
        tick(HALF);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = w[i];
        tick(HALF);
        sck = cpol;
        cap[i] = miso;
        tick(HALF);
      end
    end
    if (nbits == int'(len) + 1) exp_rx.push_back(w & len_mask(len));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(3);
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b required 1", tx_ready);
    else passed++;
    checks++;
    if (rx_data !== 32'h0) $display("FAIL reset_rx_data: got %08h required 00000000", rx_data);
    else passed++;
    checks++;
    if ({rx_valid, tx_underrun, abort} !== 3'b000)
      $display("FAIL reset_pulses: got %b required 000", {rx_valid, tx_underrun, abort});
    else passed++;
    checks++;
    if ({busy, miso, miso_oe} !== 3'b000)
      $display("FAIL reset_busy_miso: got %b required 000", {busy, miso, miso_oe});
    else passed++;
  endtask

  task automatic test_mode0();
    logic [31:0] cap, exp_w;
    int r0;
    rd_idx = obs_rx.size();
    len = 5'd7;
    load_tx(32'h91);
    tick(2);
    checks++;
    if (tx_ready !== 1'b0) $display("FAIL mode0_hold_full: tx_ready=%b required 0", tx_ready);
    else passed++;
    r0 = rx_cnt;
    frame_begin(1'b0, 1'b0);
    checks++;
    if ({tx_ready, busy, miso_oe} !== 3'b111)
      $display("FAIL mode0_start: tx_ready/busy/miso_oe=%b required 111", {tx_ready, busy, miso_oe});
    else passed++;
    spi_bits(32'hEE, 8, cap);
    frame_end();
    checks++;
    if (cap !== 32'h91) $display("FAIL mode0_miso: got %08h required 00000091", cap);
    else passed++;
    checks++;
    if (rx_cnt - r0 !== 1) $display("FAIL mode0_rx_count: got %0d required 1", rx_cnt - r0);
    else passed++;
    while (exp_rx.size() > 0) begin
      exp_w = exp_rx.pop_front();
      checks++;
      if (rd_idx >= obs_rx.size()) $display("FAIL mode0_rx: no word, required %08h", exp_w);
      else if (obs_rx[rd_idx] !== exp_w) $display("FAIL mode0_rx: got %08h required %08h", obs_rx[rd_idx], exp_w);
      else passed++;
      rd_idx++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL mode0_busy_end: got %b required 0", busy);
    else passed++;
  endtask

  task automatic test_mode3();
    logic [31:0] cap, exp_w;
    int r0, a0;
    rd_idx = obs_rx.size();
    len = 5'd15;
    load_tx(32'hA55A);
    r0 = rx_cnt;
    a0 = ab_cnt;
    frame_begin(1'b1, 1'b1);
    spi_bits(32'h1234, 16, cap);
    frame_end();
    checks++;
    if (cap !== 32'hA55A) $display("FAIL mode3_miso: got %08h required 0000a55a", cap);
    else passed++;
    checks++;
    if (ab_cnt - a0 !== 0) $display("FAIL mode3_abort: got %0d pulses required 0", ab_cnt - a0);
    else passed++;
    checks++;
    if (rx_cnt - r0 !== 1) $display("FAIL mode3_rx_count: got %0d required 1", rx_cnt - r0);
    else passed++;
    while (exp_rx.size() > 0) begin
      exp_w = exp_rx.pop_front();
      checks++;
      if (rd_idx >= obs_rx.size()) $display("FAIL mode3_rx: no word, required %08h", exp_w);
      else if (obs_rx[rd_idx] !== exp_w) $display("FAIL mode3_rx: got %08h required %08h", obs_rx[rd_idx], exp_w);
      else passed++;
      rd_idx++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap1, cap2, exp_w;
    int r0, u0;
    rd_idx = obs_rx.size();
    len = 5'd7;
    load_tx(32'h01);
    r0 = rx_cnt;
    u0 = und_cnt;
    frame_begin(1'b0, 1'b1);
    fork
      begin
        spi_bits(32'hF0, 8, cap1);
        spi_bits(32'h0F, 8, cap2);
      end
      begin
        load_tx(32'h02);
      end
    join
    frame_end();
    checks++;
    if (cap1 !== 32'h01) $display("FAIL b2b_miso0: got %08h required 00000001", cap1);
    else passed++;
    checks++;
    if (cap2 !== 32'h02) $display("FAIL b2b_miso1: got %08h required 00000002", cap2);
    else passed++;
    checks++;
    if (rx_cnt - r0 !== 2) $display("FAIL b2b_rx_count: got %0d required 2", rx_cnt - r0);
    else passed++;
    checks++;
    if (und_cnt - u0 !== 0) $display("FAIL b2b_underrun: got %0d pulses required 0", und_cnt - u0);
    else passed++;
    while (exp_rx.size() > 0) begin
      exp_w = exp_rx.pop_front();
      checks++;
      if (rd_idx >= obs_rx.size()) $display("FAIL b2b_rx: no word, required %08h", exp_w);
      else if (obs_rx[rd_idx] !== exp_w) $display("FAIL b2b_rx: got %08h required %08h", obs_rx[rd_idx], exp_w);
      else passed++;
      rd_idx++;
    end
  endtask

  task automatic test_underrun();
    logic [31:0] cap, exp_w;
    int u0;
    rd_idx = obs_rx.size();
    len = 5'd7;
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL underrun_empty: tx_ready=%b required 1", tx_ready);
    else passed++;
    u0 = und_cnt;
    frame_begin(1'b0, 1'b1);
    spi_bits(32'h3C, 8, cap);
    frame_end();
    checks++;
    if (und_cnt - u0 !== 1) $display("FAIL underrun_pulse: got %0d pulses required 1", und_cnt - u0);
    else passed++;
    checks++;
    if (cap !== 32'h0) $display("FAIL underrun_miso: got %08h required 00000000", cap);
    else passed++;
    while (exp_rx.size() > 0) begin
      exp_w = exp_rx.pop_front();
      checks++;
      if (rd_idx >= obs_rx.size()) $display("FAIL underrun_rx: no word, required %08h", exp_w);
      else if (obs_rx[rd_idx] !== exp_w) $display("FAIL underrun_rx: got %08h required %08h", obs_rx[rd_idx], exp_w);
      else passed++;
      rd_idx++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] cap, exp_w;
    int r0, a0;
    len = 5'd7;
    r0 = rx_cnt;
    a0 = ab_cnt;
    frame_begin(1'b0, 1'b0);
    spi_bits(32'hAB, 3, cap);
    frame_end();
    checks++;
    if (ab_cnt - a0 !== 1) $display("FAIL abort_pulse: got %0d pulses required 1", ab_cnt - a0);
    else passed++;
    checks++;
    if (rx_cnt - r0 !== 0) $display("FAIL abort_rx_count: got %0d required 0", rx_cnt - r0);
    else passed++;
    checks++;
    if (rx_data !== 32'h3C) $display("FAIL abort_rx_kept: got %08h required 0000003c", rx_data);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy);
    else passed++;
    rd_idx = obs_rx.size();
    load_tx(32'h66);
    frame_begin(1'b0, 1'b0);
    spi_bits(32'hC3, 8, cap);
    frame_end();
    checks++;
    if (cap !== 32'h66) $display("FAIL abort_next_miso: got %08h required 00000066", cap);
    else passed++;
    while (exp_rx.size() > 0) begin
      exp_w = exp_rx.pop_front();
      checks++;
      if (rd_idx >= obs_rx.size()) $display("FAIL abort_next_rx: no word, required %08h", exp_w);
      else if (obs_rx[rd_idx] !== exp_w) $display("FAIL abort_next_rx: got %08h required %08h", obs_rx[rd_idx], exp_w);
      else passed++;
      rd_idx++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] cap, exp_w;
    int r0, a0;
    len = 5'd7;
    r0 = rx_cnt;
    a0 = ab_cnt;
    frame_begin(1'b0, 1'b0);
    spi_bits(32'hFF, 3, cap);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    checks++;
    if ({busy, tx_ready, rx_data} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL midrst_state: busy=%b tx_ready=%b rx_data=%08h required 0 1 00000000", busy, tx_ready, rx_data);
    else passed++;
    spi_bits(32'hFF, 5, cap);
    frame_end();
    checks++;
    if ((rx_cnt - r0) + (ab_cnt - a0) !== 0)
      $display("FAIL midrst_ignored: rx_valid=%0d abort=%0d required 0 0", rx_cnt - r0, ab_cnt - a0);
    else passed++;
    rd_idx = obs_rx.size();
    frame_begin(1'b0, 1'b0);
    spi_bits(32'h5A, 8, cap);
    frame_end();
    while (exp_rx.size() > 0) begin
      exp_w = exp_rx.pop_front();
      checks++;
      if (rd_idx >= obs_rx.size()) $display("FAIL midrst_next_rx: no word, required %08h", exp_w);
      else if (obs_rx[rd_idx] !== exp_w) $display("FAIL midrst_next_rx: got %08h required %08h", obs_rx[rd_idx], exp_w);
      else passed++;
      rd_idx++;
    end
    checks++;
    if (rx_data !== 32'h5A) $display("FAIL midrst_rx_data: got %08h required 0000005a", rx_data);
    else passed++;
  endtask

  initial begin
    tick(1);
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
